// File: rtl/maze_query_arbiter.sv
// Maze query arbiter: round-robin grant of up to four tile wall queries onto a
// single synchronous level-map ROM. Each granted query flows through a three
// stage pipeline (address, ROM read, response) carrying its requester ID so
// responses come back in grant order, one per cycle at most.
module maze_query_arbiter #(
    parameter int TILES_X = 28,
    parameter int TILES_Y = 36
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [19:0] req_tx,
    input  logic [23:0] req_ty,
    output logic [3:0]  gnt,
    output logic [9:0]  rom_addr,
    input  logic        rom_data,
    output logic [3:0]  rsp_valid,
    output logic        rsp_wall,
    output logic        rsp_oob,
    output logic        busy
);

    logic [1:0] ptr_q, ptr_d;
    logic       gnt_any;
    logic [1:0] gnt_id;
    logic [1:0] cand;

    logic [4:0] sel_x;
    logic [5:0] sel_y;
    logic [9:0] sel_idx;
    logic       sel_oob;

    logic       s1_valid_q, s1_valid_d;
    logic [1:0] s1_id_q, s1_id_d;
    logic       s1_oob_q, s1_oob_d;
    logic [9:0] rom_addr_q, rom_addr_d;

    logic       s2_valid_q;
    logic [1:0] s2_id_q;
    logic       s2_oob_q;

    logic [3:0] rsp_valid_q, rsp_valid_d;
    logic       rsp_wall_q, rsp_wall_d;
    logic       rsp_oob_q, rsp_oob_d;

    // Round-robin search starting at the pointer; nothing is granted while
    // disabled or while reset is asserted.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 2'd0;
        cand    = 2'd0;
        if (rst_n && en) begin
            for (int k = 0; k < 4; k++) begin
                cand = ptr_q + 2'(k);
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
    end

    // Pick the winner's coordinates, form y*28+x by shifts and flag tiles
    // outside the maze so they read as walls without touching the ROM.
    always_comb begin
        sel_x   = req_tx[gnt_id*5 +: 5];
        sel_y   = req_ty[gnt_id*6 +: 6];
        sel_idx = 10'({sel_y, 5'b00000}) - 10'({sel_y, 2'b00}) + 10'(sel_x);
        sel_oob = (int'(sel_x) >= TILES_X) || (int'(sel_y) >= TILES_Y);
    end

    // Next-state for the pointer and the address stage; the address only
    // moves when a query is granted so an idle cycle leaves it untouched.
    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = gnt_any;
        s1_id_d    = s1_id_q;
        s1_oob_d   = s1_oob_q;
        rom_addr_d = rom_addr_q;
        if (gnt_any) begin
            ptr_d      = gnt_id + 2'd1;
            s1_id_d    = gnt_id;
            s1_oob_d   = sel_oob;
            rom_addr_d = sel_oob ? 10'd0 : sel_idx;
        end
    end

    // Response stage: combine the ROM bit (or forced wall for out-of-bounds)
    // with the requester ID that travelled alongside the read.
    always_comb begin
        rsp_valid_d = 4'b0000;
        rsp_wall_d  = 1'b0;
        rsp_oob_d   = 1'b0;
        if (s2_valid_q) begin
            rsp_valid_d = 4'(4'b0001 << s2_id_q);
            rsp_wall_d  = s2_oob_q | rom_data;
            rsp_oob_d   = s2_oob_q;
        end
    end

    // All pipeline state; reset drops anything in flight.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= 2'd0;
            s1_oob_q    <= 1'b0;
            rom_addr_q  <= 10'd0;
            s2_valid_q  <= 1'b0;
            s2_id_q     <= 2'd0;
            s2_oob_q    <= 1'b0;
            rsp_valid_q <= 4'b0000;
            rsp_wall_q  <= 1'b0;
            rsp_oob_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_oob_q    <= s1_oob_d;
            rom_addr_q  <= rom_addr_d;
            s2_valid_q  <= s1_valid_q;
            s2_id_q     <= s1_id_q;
            s2_oob_q    <= s1_oob_q;
            rsp_valid_q <= rsp_valid_d;
            rsp_wall_q  <= rsp_wall_d;
            rsp_oob_q   <= rsp_oob_d;
        end
    end

    assign gnt       = gnt_any ? 4'(4'b0001 << gnt_id) : 4'b0000;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_wall  = rsp_wall_q;
    assign rsp_oob   = rsp_oob_q;
    assign busy      = s1_valid_q | s2_valid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_maze_query_arbiter.sv
// Directed testbench for maze_query_arbiter with a behavioural synchronous
// level-map ROM. Inputs change on the falling edge; outputs are checked 1ns
// later, so combinational grants and registered outputs are both settled.
module tb_maze_query_arbiter;

    logic        pclk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req;
    logic [19:0] req_tx;
    logic [23:0] req_ty;
    logic [3:0]  gnt;
    logic [9:0]  rom_addr;
    logic        rom_data;
    logic [3:0]  rsp_valid;
    logic        rsp_wall;
    logic        rsp_oob;
    logic        busy;

    logic        rom_mem [0:1023];

    int checks;
    int errors;

    maze_query_arbiter #(.TILES_X(28), .TILES_Y(36)) dut (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .req_tx    (req_tx),
        .req_ty    (req_ty),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_wall  (rsp_wall),
        .rsp_oob   (rsp_oob),
        .busy      (busy)
    );

    // Free-running pixel clock.
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Synchronous ROM: data appears the cycle after the address.
    always @(posedge pclk) begin
        rom_data <= rom_mem[rom_addr];
    end

    task automatic next_cycle;
        @(negedge pclk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b1;
        req   = 4'hF;
        next_cycle;
        next_cycle;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (rom_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
        checks++; if (rsp_wall !== 1'b0 || rsp_oob !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_flags: got wall=%b oob=%b expected 0/0", rsp_wall, rsp_oob); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        next_cycle;
        rst_n = 1'b1;
        req   = 4'h0;
    endtask

    task automatic test_single_query;
        next_cycle;
        req          = 4'b0001;
        req_tx[4:0]  = 5'd13;
        req_ty[5:0]  = 6'd26;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL single_gnt: got %b expected 0001", gnt); end
        next_cycle;
        req = 4'b0000;
        #1;
        checks++; if (rom_addr !== 10'd741) begin errors++; $display("[TB] FAIL single_rom_addr: got %0d expected 741", rom_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %b expected 1", busy); end
        next_cycle;
        #1;
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL single_early_rsp: got %b expected 0000", rsp_valid); end
        next_cycle;
        #1;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("[TB] FAIL single_rsp_valid: got %b expected 0001", rsp_valid); end
        checks++; if (rsp_wall !== 1'b0 || rsp_oob !== 1'b0) begin errors++; $display("[TB] FAIL single_rsp_flags: got wall=%b oob=%b expected 0/0", rsp_wall, rsp_oob); end
        next_cycle;
        #1;
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_drain: got rsp=%b busy=%b expected 0000/0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g [5];
        logic [9:0] exp_a [5];
        logic       exp_w [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_a = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd0};
        exp_w = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        next_cycle;
        rst_n = 1'b0;
        next_cycle;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_tx[i*5 +: 5] = 5'(i);
            req_ty[i*6 +: 6] = 6'd0;
        end
        for (int c = 0; c < 8; c++) begin
            next_cycle;
            req = (c < 5) ? 4'hF : 4'h0;
            #1;
            if (c < 5) begin
                checks++; if (gnt !== exp_g[c]) begin errors++; $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", c, gnt, exp_g[c]); end
            end
            if (c >= 1 && c <= 5) begin
                checks++; if (rom_addr !== exp_a[c-1]) begin errors++; $display("[TB] FAIL rr_rom_addr[%0d]: got %0d expected %0d", c, rom_addr, exp_a[c-1]); end
            end
            if (c >= 3) begin
                checks++; if (rsp_valid !== exp_g[c-3]) begin errors++; $display("[TB] FAIL rr_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, exp_g[c-3]); end
                checks++; if (rsp_wall !== exp_w[c-3] || rsp_oob !== 1'b0) begin errors++; $display("[TB] FAIL rr_rsp_flags[%0d]: got wall=%b oob=%b expected %b/0", c, rsp_wall, rsp_oob, exp_w[c-3]); end
            end
        end
    endtask

    task automatic test_bounds;
        // Far corner of the maze, still in bounds.
        next_cycle;
        req           = 4'b0010;
        req_tx[9:5]   = 5'd27;
        req_ty[11:6]  = 6'd35;
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL corner_gnt: got %b expected 0010", gnt); end
        next_cycle;
        req = 4'b0000;
        #1;
        checks++; if (rom_addr !== 10'd1007) begin errors++; $display("[TB] FAIL corner_rom_addr: got %0d expected 1007", rom_addr); end
        next_cycle;
        next_cycle;
        #1;
        checks++; if (rsp_valid !== 4'b0010 || rsp_wall !== 1'b1 || rsp_oob !== 1'b0) begin errors++; $display("[TB] FAIL corner_rsp: got rsp=%b wall=%b oob=%b expected 0010/1/0", rsp_valid, rsp_wall, rsp_oob); end
        next_cycle;
        #1;
        checks++; if (rom_addr !== 10'd1007 || rsp_valid !== 4'b0000) begin errors++; $display("[TB] FAIL idle_hold: got addr=%0d rsp=%b expected 1007/0000", rom_addr, rsp_valid); end
        // X out of range, then Y out of range back to back.
        next_cycle;
        req            = 4'b0100;
        req_tx[14:10]  = 5'd28;
        req_ty[17:12]  = 6'd5;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL oobx_gnt: got %b expected 0100", gnt); end
        next_cycle;
        req            = 4'b1000;
        req_tx[19:15]  = 5'd0;
        req_ty[23:18]  = 6'd36;
        #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("[TB] FAIL ooby_gnt: got %b expected 1000", gnt); end
        checks++; if (rom_addr !== 10'd0) begin errors++; $display("[TB] FAIL oobx_rom_addr: got %0d expected 0", rom_addr); end
        next_cycle;
        req = 4'b0000;
        #1;
        checks++; if (rom_addr !== 10'd0) begin errors++; $display("[TB] FAIL ooby_rom_addr: got %0d expected 0", rom_addr); end
        next_cycle;
        #1;
        checks++; if (rsp_valid !== 4'b0100 || rsp_wall !== 1'b1 || rsp_oob !== 1'b1) begin errors++; $display("[TB] FAIL oobx_rsp: got rsp=%b wall=%b oob=%b expected 0100/1/1", rsp_valid, rsp_wall, rsp_oob); end
        next_cycle;
        #1;
        checks++; if (rsp_valid !== 4'b1000 || rsp_wall !== 1'b1 || rsp_oob !== 1'b1) begin errors++; $display("[TB] FAIL ooby_rsp: got rsp=%b wall=%b oob=%b expected 1000/1/1", rsp_valid, rsp_wall, rsp_oob); end
        next_cycle;
        #1;
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL oob_drain: got rsp=%b busy=%b expected 0000/0", rsp_valid, busy); end
    endtask

    task automatic test_enable;
        for (int i = 0; i < 4; i++) begin
            req_tx[i*5 +: 5] = 5'(i);
            req_ty[i*6 +: 6] = 6'd0;
        end
        for (int c = 0; c < 5; c++) begin
            next_cycle;
            en  = 1'b0;
            req = 4'b0110;
            #1;
            checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL en_blocked[%0d]: got gnt=%b busy=%b expected 0000/0", c, gnt, busy); end
        end
        next_cycle;
        en = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL en_rise_gnt: got %b expected 0010", gnt); end
        next_cycle;
        en = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b1) begin errors++; $display("[TB] FAIL en_drop: got gnt=%b busy=%b expected 0000/1", gnt, busy); end
        next_cycle;
        next_cycle;
        #1;
        checks++; if (rsp_valid !== 4'b0010 || rsp_wall !== 1'b1 || rsp_oob !== 1'b0) begin errors++; $display("[TB] FAIL en_inflight_rsp: got rsp=%b wall=%b oob=%b expected 0010/1/0", rsp_valid, rsp_wall, rsp_oob); end
        next_cycle;
        req = 4'b0000;
        en  = 1'b1;
    endtask

    task automatic test_reset_midflight;
        next_cycle;
        req = 4'b0010;
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL mid_gnt: got %b expected 0010", gnt); end
        next_cycle;
        req   = 4'hF;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000 || rom_addr !== 10'd0 || rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_wall !== 1'b0 || rsp_oob !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_outputs: got gnt=%b addr=%0d rsp=%b busy=%b wall=%b oob=%b expected all 0", gnt, rom_addr, rsp_valid, busy, rsp_wall, rsp_oob); end
        next_cycle;
        next_cycle;
        rst_n = 1'b1;
        req   = 4'h0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_dropped[%0d]: got rsp=%b busy=%b expected 0000/0", c, rsp_valid, busy); end
            next_cycle;
        end
        req = 4'hF;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL mid_ptr_restart: got %b expected 0001", gnt); end
        next_cycle;
        req = 4'h0;
    endtask

    // Test sequence: ROM contents first, then each scenario in turn.
    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        req    = 4'h0;
        req_tx = '0;
        req_ty = '0;
        for (int a = 0; a < 1024; a++) rom_mem[a] = 1'b1;
        rom_mem[0]    = 1'b0;
        rom_mem[1]    = 1'b1;
        rom_mem[2]    = 1'b0;
        rom_mem[3]    = 1'b1;
        rom_mem[741]  = 1'b0;
        rom_mem[1007] = 1'b1;

        test_reset;
        test_single_query;
        test_round_robin;
        test_bounds;
        test_enable;
        test_reset_midflight;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
